// File: rtl/vga_ctrl_param_if.sv
// rtl/vga_ctrl_param_if.sv - pixel fetch and VGA output bundle for vga_ctrl_param
interface vga_ctrl_param_if #(
  parameter int COLOR_W = 4,
  parameter int ADDR_W  = 10
);
  logic [1:0]           pattern_sel;
  logic [3*COLOR_W-1:0] pix_data;
  logic [ADDR_W-1:0]    h_addr;
  logic [ADDR_W-1:0]    v_addr;
  logic                 fetch_valid;
  logic                 frame_start;
  logic                 hsync;
  logic                 vsync;
  logic                 valid;
  logic [7:0]           vga_r;
  logic [7:0]           vga_g;
  logic [7:0]           vga_b;

  modport master (
    input  pattern_sel, pix_data,
    output h_addr, v_addr, fetch_valid, frame_start,
    output hsync, vsync, valid, vga_r, vga_g, vga_b
  );

  modport slave (
    output pattern_sel, pix_data,
    input  h_addr, v_addr, fetch_valid, frame_start,
    input  hsync, vsync, valid, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_ctrl_param.sv
// rtl/vga_ctrl_param.sv - parametrised VGA timing generator with latency-matched pixel output
// Fetch addresses are issued at cycle t; sync, de and colour leave registered at t+RD_LATENCY+1.
module vga_ctrl_param #(
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int RD_LATENCY = 1,
  parameter int COLOR_W    = 4,
  parameter int ADDR_W     = 10
) (
  input logic              pclk,
  input logic              reset,
  vga_ctrl_param_if.master vif
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int DW      = 6;

  localparam logic [ADDR_W-1:0] H_LAST   = ADDR_W'(H_TOTAL - 1);
  localparam logic [ADDR_W-1:0] V_LAST   = ADDR_W'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] H_SW     = ADDR_W'(H_SYNC);
  localparam logic [ADDR_W-1:0] V_SW     = ADDR_W'(V_SYNC);
  localparam logic [ADDR_W-1:0] H_BEG    = ADDR_W'(H_SYNC + H_BACK);
  localparam logic [ADDR_W-1:0] V_BEG    = ADDR_W'(V_SYNC + V_BACK);
  localparam logic [ADDR_W-1:0] H_END    = ADDR_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [ADDR_W-1:0] V_END    = ADDR_W'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_ALAST  = ADDR_W'(H_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] V_ALAST  = ADDR_W'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] BAR_LAST = ADDR_W'(BAR_W - 1);
  localparam logic              HS_ON    = (HSYNC_POL != 0);
  localparam logic              VS_ON    = (VSYNC_POL != 0);

  logic [ADDR_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] h_addr, v_addr;
  logic              h_act, v_act, de_raw, hs_raw, vs_raw, frame_start;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  assign h_act       = (h_cnt_q >= H_BEG) && (h_cnt_q < H_END);
  assign v_act       = (v_cnt_q >= V_BEG) && (v_cnt_q < V_END);
  assign de_raw      = h_act && v_act;
  assign hs_raw      = h_cnt_q < H_SW;
  assign vs_raw      = v_cnt_q < V_SW;
  assign h_addr      = h_act ? h_cnt_q - H_BEG : '0;
  assign v_addr      = v_act ? v_cnt_q - V_BEG : '0;
  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);

  // Bar position restarts on the first active pixel of each line, so no divider is needed.
  logic [ADDR_W-1:0] bar_pix_q, bar_pix_d, bar_pix_cur;
  logic [2:0]        bar_idx_q, bar_idx_d, bar_idx_cur;
  logic              line_first;

  assign line_first = (h_cnt_q == H_BEG);

  always_comb begin
    bar_pix_cur = line_first ? '0 : bar_pix_q;
    bar_idx_cur = line_first ? '0 : bar_idx_q;
    bar_pix_d   = bar_pix_q;
    bar_idx_d   = bar_idx_q;
    if (h_act) begin
      if (bar_pix_cur == BAR_LAST) begin
        bar_pix_d = '0;
        bar_idx_d = bar_idx_cur + 3'd1;
      end else begin
        bar_pix_d = bar_pix_cur + 1'b1;
        bar_idx_d = bar_idx_cur;
      end
    end
  end

  logic [1:0] pat_q, pat_d;
  logic [2:0] pat_rgb;
  logic       grid_on;

  assign grid_on = (h_addr[3:0] == 4'd0) || (v_addr[3:0] == 4'd0) ||
                   (h_addr == H_ALAST) || (v_addr == V_ALAST);

  always_comb begin
    pat_d = frame_start ? vif.pattern_sel : pat_q;
    case (pat_q)
      2'd1:    pat_rgb = ~bar_idx_cur;
      2'd2:    pat_rgb = {3{grid_on}};
      default: pat_rgb = 3'b111;
    endcase
  end

  logic [DW-1:0] stage_in, stage_out;
  assign stage_in = {hs_raw, vs_raw, de_raw, pat_rgb};

  generate
    if (RD_LATENCY == 0) begin : g_nodly
      assign stage_out = stage_in;
    end else begin : g_dly
      logic [DW-1:0] dly_q [RD_LATENCY];
      always_ff @(posedge pclk) begin
        if (reset) begin
          for (int i = 0; i < RD_LATENCY; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= stage_in;
          for (int i = 1; i < RD_LATENCY; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign stage_out = dly_q[RD_LATENCY-1];
    end
  endgenerate

  logic       hs_dly, vs_dly, de_dly;
  logic [2:0] pat_dly;
  assign {hs_dly, vs_dly, de_dly, pat_dly} = stage_out;

  function automatic logic [7:0] expand(input logic [COLOR_W-1:0] c);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) e[7-i] = c[COLOR_W-1-(i % COLOR_W)];
    return e;
  endfunction

  logic [7:0] r_d, g_d, b_d, r_q, g_q, b_q;
  logic       valid_q, hsync_q, vsync_q;

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (de_dly) begin
      if (pat_q == 2'd0) begin
        r_d = expand(vif.pix_data[3*COLOR_W-1 -: COLOR_W]);
        g_d = expand(vif.pix_data[2*COLOR_W-1 -: COLOR_W]);
        b_d = expand(vif.pix_data[COLOR_W-1:0]);
      end else begin
        r_d = {8{pat_dly[2]}};
        g_d = {8{pat_dly[1]}};
        b_d = {8{pat_dly[0]}};
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      pat_q     <= '0;
      bar_pix_q <= '0;
      bar_idx_q <= '0;
      valid_q   <= 1'b0;
      hsync_q   <= ~HS_ON;
      vsync_q   <= ~VS_ON;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      pat_q     <= pat_d;
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
      valid_q   <= de_dly;
      hsync_q   <= hs_dly ? HS_ON : ~HS_ON;
      vsync_q   <= vs_dly ? VS_ON : ~VS_ON;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign vif.h_addr      = h_addr;
  assign vif.v_addr      = v_addr;
  assign vif.fetch_valid = de_raw;
  assign vif.frame_start = frame_start;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.valid       = valid_q;
  assign vif.vga_r       = r_q;
  assign vif.vga_g       = g_q;
  assign vif.vga_b       = b_q;
endmodule
